// File: rtl/serial_frame_tx_if.sv
// Handshake/data bundle between a frame producer and serial_frame_tx.
// Latency: none (wires only).
// Backpressure: the producer holds off while ready=0; a start seen with ready=0 is dropped.
// Ports: start/hdr/payload (producer -> tx), ready/serOut/busy/done (tx -> producer/line).
interface serial_frame_tx_if #(
   parameter int HDR_W = 8,
   parameter int PAY_W = 7
);
   logic             start;
   logic [HDR_W-1:0] hdr;
   logic [PAY_W-1:0] payload;
   logic             ready;
   logic             serOut;
   logic             busy;
   logic             done;

   modport master (
      output start, hdr, payload,
      input  ready, serOut, busy, done
   );

   modport slave (
      input  start, hdr, payload,
      output ready, serOut, busy, done
   );
endinterface

// File: rtl/serial_frame_tx.sv
// Serialises {hdr,payload} as start bit (0), header MSB-first, payload MSB-first, stop (1).
// Latency: start bit appears on serOut in the cycle after the accepting edge.
// Backpressure: one-entry holding buffer; ready=0 while it is full and starts are then ignored.
// Ports: clk, rst (async, active-high), txIf.slave (start/hdr/payload in; ready/serOut/busy/done out).
module serial_frame_tx #(
   parameter int HDR_W    = 8,
   parameter int PAY_W    = 7,
   parameter int STOP_CYC = 1
) (
   input logic             clk,
   input logic             rst,
   serial_frame_tx_if.slave txIf
);

   localparam int FR_W  = HDR_W + PAY_W;
   localparam int MAXN  = (HDR_W > PAY_W) ? ((HDR_W > STOP_CYC) ? HDR_W : STOP_CYC)
                                          : ((PAY_W > STOP_CYC) ? PAY_W : STOP_CYC);
   localparam int CNT_W = (MAXN > 1) ? $clog2(MAXN) : 1;

   // Counters count down to zero; the reload value is "cycles in state - 1".
   localparam logic [CNT_W-1:0] HDR_RL  = CNT_W'(HDR_W - 1);
   localparam logic [CNT_W-1:0] PAY_RL  = CNT_W'(PAY_W - 1);
   localparam logic [CNT_W-1:0] STOP_RL = CNT_W'(STOP_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      HDR,
      PAY,
      STOP
   } state_t;

   state_t            stateQ, stateD;
   logic [CNT_W-1:0]  cntQ, cntD;
   logic [FR_W-1:0]   shQ, shD;
   logic [FR_W-1:0]   bufQ, bufD;
   logic              bufVldQ, bufVldD;
   logic              serOutQ, serOutD;
   logic              doneQ, doneD;
   logic              readyQ;

   logic              accept;
   logic              lastStop;
   logic [FR_W-1:0]   frameIn;

   assign frameIn  = {txIf.hdr, txIf.payload};
   assign accept   = txIf.start && readyQ;
   assign lastStop = (stateQ == STOP) && (cntQ == '0);

   always_comb begin
      stateD  = stateQ;
      cntD    = cntQ;
      shD     = shQ;
      bufD    = bufQ;
      bufVldD = bufVldQ;
      serOutD = 1'b1;
      doneD   = 1'b0;

      case (stateQ)
         IDLE: begin
            if (accept) begin
               stateD = START;
               shD    = frameIn;
               cntD   = '0;
            end
         end
         START: begin
            stateD = HDR;
            cntD   = HDR_RL;
         end
         HDR: begin
            shD = {shQ[FR_W-2:0], 1'b0};
            if (cntQ == '0) begin
               stateD = PAY;
               cntD   = PAY_RL;
            end else begin
               cntD = cntQ - CNT_W'(1);
            end
         end
         PAY: begin
            shD = {shQ[FR_W-2:0], 1'b0};
            if (cntQ == '0) begin
               stateD = STOP;
               cntD   = STOP_RL;
            end else begin
               cntD = cntQ - CNT_W'(1);
            end
         end
         STOP: begin
            if (cntQ != '0) begin
               cntD = cntQ - CNT_W'(1);
            end else if (bufVldQ) begin
               // Buffered frame follows with no idle gap; ready is low here so no accept can collide.
               stateD  = START;
               shD     = bufQ;
               bufVldD = 1'b0;
               cntD    = '0;
            end else if (accept) begin
               stateD = START;
               shD    = frameIn;
               cntD   = '0;
            end else begin
               stateD = IDLE;
               cntD   = '0;
            end
         end
         default: begin
            stateD = IDLE;
            cntD   = '0;
         end
      endcase

      // Any acceptance that cannot go straight into the shifter parks in the holding buffer.
      if (accept && (stateQ != IDLE) && !lastStop) begin
         bufD    = frameIn;
         bufVldD = 1'b1;
      end

      // serOut and done are registered from next-state values so the line never glitches.
      case (stateD)
         START:   serOutD = 1'b0;
         HDR,
         PAY:     serOutD = shD[FR_W-1];
         default: serOutD = 1'b1;
      endcase
      doneD = (stateD == STOP) && (cntD == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ  <= IDLE;
         cntQ    <= '0;
         shQ     <= '0;
         bufQ    <= '0;
         bufVldQ <= 1'b0;
         serOutQ <= 1'b1;
         doneQ   <= 1'b0;
         readyQ  <= 1'b1;
      end else begin
         stateQ  <= stateD;
         cntQ    <= cntD;
         shQ     <= shD;
         bufQ    <= bufD;
         bufVldQ <= bufVldD;
         serOutQ <= serOutD;
         doneQ   <= doneD;
         readyQ  <= !bufVldD;
      end
   end

   assign txIf.ready  = readyQ;
   assign txIf.serOut = serOutQ;
   assign txIf.done   = doneQ;
   assign txIf.busy   = (stateQ != IDLE);

endmodule
